// File: rtl/data_path.sv
// Single-bus 32-bit datapath: R0-R15, HI, LO, PC, IR, Y, MAR, MDR, 64-bit Z and a combinational ALU.
// Define DATAPATH_MULDIV_EN to build the signed multiplier/divider; otherwise MUL/DIV load Z with zero.
module data_path (
    input  logic        Clock,
    input  logic        Clear,
    input  logic        HIin, HIout, LOin, LOout, PCin, PCout, IRin, Zin,
    input  logic        Zhighout, Zlowout, Yin, MARin, MDRin, MDRout, Read,
    input  logic [31:0] Mdatain,
    input  logic        R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
    input  logic        R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
    input  logic        R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
    input  logic        R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
    input  logic        ADD, SUB, SHR, SHRA, SHL, ROR, ROL, AND, OR, MUL, DIV, NEG, NOT,
    output logic [31:0] BusMuxOut
);

    logic [15:0] r_out, r_in;
    logic [31:0] regs [16];
    logic [31:0] hi, lo, pc, ir, y, mar, mdr;
    logic [63:0] z, alu, mul_res, div_res, rot_r, rot_l;
    logic [4:0]  sh;
    logic        unused_regs;

    assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                    R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
    assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                    R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};

    // MAR and IR feed memory and decode logic outside this block.
    assign unused_regs = ^{ir, mar};

    // Later assignments win: lowest-numbered register has highest priority.
    always_comb begin
        BusMuxOut = '0;
        if (MDRout)   BusMuxOut = mdr;
        if (PCout)    BusMuxOut = pc;
        if (Zlowout)  BusMuxOut = z[31:0];
        if (Zhighout) BusMuxOut = z[63:32];
        if (LOout)    BusMuxOut = lo;
        if (HIout)    BusMuxOut = hi;
        for (int unsigned i = 16; i > 0; i--) begin
            if (r_out[i-1]) BusMuxOut = regs[i-1];
        end
    end

    assign sh    = BusMuxOut[4:0];
    assign rot_r = {y, y} >> sh;
    assign rot_l = {y, y} << sh;

`ifdef DATAPATH_MULDIV_EN
    logic signed [63:0] product;
    logic signed [31:0] quot, rem;
    logic               div_zero;

    assign product  = $signed({{32{y[31]}}, y}) * $signed({{32{BusMuxOut[31]}}, BusMuxOut});
    assign div_zero = (BusMuxOut == '0);
    assign quot     = div_zero ? '1 : $signed(y) / $signed(BusMuxOut);
    assign rem      = div_zero ? $signed(y) : $signed(y) % $signed(BusMuxOut);
    assign mul_res  = product;
    assign div_res  = {rem, quot};
`else
    assign mul_res = '0;
    assign div_res = '0;
`endif

    always_comb begin
        alu = '0;
        if (ADD)       alu = {32'h0, y + BusMuxOut};
        else if (SUB)  alu = {32'h0, y - BusMuxOut};
        else if (SHR)  alu = {32'h0, y >> sh};
        else if (SHRA) alu = {32'h0, $signed(y) >>> sh};
        else if (SHL)  alu = {32'h0, y << sh};
        else if (ROR)  alu = {32'h0, rot_r[31:0]};
        else if (ROL)  alu = {32'h0, rot_l[63:32]};
        else if (AND)  alu = {32'h0, y & BusMuxOut};
        else if (OR)   alu = {32'h0, y | BusMuxOut};
        else if (MUL)  alu = mul_res;
        else if (DIV)  alu = div_res;
        else if (NEG)  alu = {32'h0, 32'h0 - BusMuxOut};
        else if (NOT)  alu = {32'h0, ~BusMuxOut};
        else           alu = {32'h0, BusMuxOut + 32'h1};
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            for (int unsigned i = 0; i < 16; i++) regs[i] <= '0;
            hi  <= '0;
            lo  <= '0;
            pc  <= '0;
            ir  <= '0;
            y   <= '0;
            mar <= '0;
            mdr <= '0;
            z   <= '0;
        end else begin
            for (int unsigned i = 0; i < 16; i++) begin
                if (r_in[i]) regs[i] <= BusMuxOut;
            end
            if (HIin)  hi  <= BusMuxOut;
            if (LOin)  lo  <= BusMuxOut;
            if (PCin)  pc  <= BusMuxOut;
            if (IRin)  ir  <= BusMuxOut;
            if (Yin)   y   <= BusMuxOut;
            if (MARin) mar <= BusMuxOut;
            if (MDRin) mdr <= Read ? Mdatain : BusMuxOut;
            if (Zin)   z   <= alu;
        end
    end

endmodule

// File: tb/tb_data_path.sv
// Scoreboard bench for data_path: expectations are queued with the bus select that exposes them.
// Expected MUL/DIV results follow DATAPATH_MULDIV_EN.
module tb_data_path;

    localparam int OP_ADD = 0,  OP_SUB = 1, OP_SHR = 2, OP_SHRA = 3, OP_SHL = 4;
    localparam int OP_ROR = 5,  OP_ROL = 6, OP_AND = 7, OP_OR = 8,   OP_MUL = 9;
    localparam int OP_DIV = 10, OP_NEG = 11, OP_NOT = 12;
    localparam int S_HI = 16, S_LO = 17, S_ZH = 18, S_ZL = 19, S_PC = 20, S_MDR = 21;
    localparam int S_NONE = 22, S_R0_HI = 23, S_HI_MDR = 24;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } sb_entry_t;

    logic        Clock = 1'b0;
    logic        Clear;
    logic        HIin, HIout, LOin, LOout, PCin, PCout, IRin, Zin;
    logic        Zhighout, Zlowout, Yin, MARin, MDRin, MDRout, Read;
    logic [31:0] Mdatain;
    logic [15:0] rout, rin;
    logic [12:0] ops;
    logic [31:0] BusMuxOut;

    sb_entry_t   sb_q[$];
    int          checks = 0;
    int          failures = 0;

    data_path dut (
        .Clock(Clock), .Clear(Clear), .HIin(HIin), .HIout(HIout), .LOin(LOin), .LOout(LOout),
        .PCin(PCin), .PCout(PCout), .IRin(IRin), .Zin(Zin), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .Yin(Yin), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .Mdatain(Mdatain),
        .R0out(rout[0]), .R1out(rout[1]), .R2out(rout[2]), .R3out(rout[3]),
        .R4out(rout[4]), .R5out(rout[5]), .R6out(rout[6]), .R7out(rout[7]),
        .R8out(rout[8]), .R9out(rout[9]), .R10out(rout[10]), .R11out(rout[11]),
        .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
        .R0in(rin[0]), .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]),
        .R4in(rin[4]), .R5in(rin[5]), .R6in(rin[6]), .R7in(rin[7]),
        .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]), .R11in(rin[11]),
        .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
        .ADD(ops[OP_ADD]), .SUB(ops[OP_SUB]), .SHR(ops[OP_SHR]), .SHRA(ops[OP_SHRA]),
        .SHL(ops[OP_SHL]), .ROR(ops[OP_ROR]), .ROL(ops[OP_ROL]), .AND(ops[OP_AND]),
        .OR(ops[OP_OR]), .MUL(ops[OP_MUL]), .DIV(ops[OP_DIV]), .NEG(ops[OP_NEG]),
        .NOT(ops[OP_NOT]), .BusMuxOut(BusMuxOut)
    );

    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_ctl();
        Clear = 0; HIin = 0; HIout = 0; LOin = 0; LOout = 0; PCin = 0; PCout = 0;
        IRin = 0; Zin = 0; Zhighout = 0; Zlowout = 0; Yin = 0; MARin = 0;
        MDRin = 0; MDRout = 0; Read = 0; Mdatain = '0; rout = '0; rin = '0; ops = '0;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic drive_sel(input int s);
        clear_ctl();
        if (s < 16) rout[s] = 1'b1;
        case (s)
            S_HI:     HIout = 1;
            S_LO:     LOout = 1;
            S_ZH:     Zhighout = 1;
            S_ZL:     Zlowout = 1;
            S_PC:     PCout = 1;
            S_MDR:    MDRout = 1;
            S_R0_HI:  begin rout[0] = 1; HIout = 1; end
            S_HI_MDR: begin HIout = 1; MDRout = 1; end
            default:  ;
        endcase
    endtask

    task automatic expect_sel(input string tag, input int sel, input logic [31:0] exp);
        sb_entry_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        sb_entry_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            drive_sel(e.sel);
            #1;
            check_eq(e.tag, BusMuxOut, e.exp);
        end
        clear_ctl();
    endtask

    task automatic mdr_load(input logic [31:0] v);
        clear_ctl();
        Read = 1; MDRin = 1; Mdatain = v;
        tick();
        clear_ctl();
    endtask

    task automatic reg_load(input int k, input logic [31:0] v);
        mdr_load(v);
        MDRout = 1;
        if (k < 16) rin[k] = 1'b1;
        else if (k == S_HI) HIin = 1;
        else if (k == S_PC) PCin = 1;
        else if (k == 99) Yin = 1;
        tick();
        clear_ctl();
    endtask

    function automatic logic [63:0] alu_model(input logic [12:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        int          n;
        longint      p;
        n = int'(b[4:0]);
        r = a;
        if (op == '0) return {32'h0, b + 32'd1};
        if (op[OP_ADD]) return {32'h0, a + b};
        if (op[OP_SUB]) return {32'h0, a - b};
        if (op[OP_SHR] || op[OP_SHRA]) begin
            for (int i = 0; i < n; i++) r = {(op[OP_SHR] ? 1'b0 : r[31]), r[31:1]};
            return {32'h0, r};
        end
        if (op[OP_SHL]) begin
            for (int i = 0; i < n; i++) r = {r[30:0], 1'b0};
            return {32'h0, r};
        end
        if (op[OP_ROR]) begin
            for (int i = 0; i < n; i++) r = {r[0], r[31:1]};
            return {32'h0, r};
        end
        if (op[OP_ROL]) begin
            for (int i = 0; i < n; i++) r = {r[30:0], r[31]};
            return {32'h0, r};
        end
        if (op[OP_AND]) return {32'h0, a & b};
        if (op[OP_OR])  return {32'h0, a | b};
`ifdef DATAPATH_MULDIV_EN
        if (op[OP_MUL]) begin
            p = longint'(signed'(a)) * longint'(signed'(b));
            return p;
        end
        if (op[OP_DIV]) begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            return {32'(signed'(a) % signed'(b)), 32'(signed'(a) / signed'(b))};
        end
`else
        if (op[OP_MUL] || op[OP_DIV]) return '0;
`endif
        if (op[OP_NEG]) return {32'h0, -b};
        return {32'h0, ~b};
    endfunction

    task automatic alu_run(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [12:0] op);
        logic [63:0] e;
        reg_load(99, a);
        mdr_load(b);
        MDRout = 1; ops = op; Zin = 1;
        tick();
        clear_ctl();
        e = alu_model(op, a, b);
        expect_sel({tag, "_zlo"}, S_ZL, e[31:0]);
        expect_sel({tag, "_zhi"}, S_ZH, e[63:32]);
        drain();
    endtask

    initial begin
        logic [12:0] op;
        logic [63:0] ref_z;
        int          pick;
        clear_ctl();
        Clear = 1;
        tick();
        clear_ctl();

        expect_sel("rst_bus_none", S_NONE, 32'h0);
        expect_sel("rst_r0", 0, 32'h0);
        expect_sel("rst_r15", 15, 32'h0);
        expect_sel("rst_hi", S_HI, 32'h0);
        expect_sel("rst_pc", S_PC, 32'h0);
        expect_sel("rst_mdr", S_MDR, 32'h0);
        expect_sel("rst_zhi", S_ZH, 32'h0);
        expect_sel("rst_zlo", S_ZL, 32'h0);
        drain();

        // ROR scenario: R1 = ROR(R2, R3)
        reg_load(2, 32'h8000_0012);
        reg_load(3, 32'h0000_0004);
        rout[2] = 1; Yin = 1; tick(); clear_ctl();
        rout[3] = 1; ops[OP_ROR] = 1; Zin = 1; tick(); clear_ctl();
        Zlowout = 1; rin[1] = 1; tick(); clear_ctl();
        expect_sel("ror_r1", 1, 32'h2800_0001);
        expect_sel("ror_zhi", S_ZH, 32'h0);
        drain();

        // PC increment through Z
        reg_load(S_PC, 32'h0000_0005);
        PCout = 1; MARin = 1; Zin = 1; tick(); clear_ctl();
        Zlowout = 1; PCin = 1; tick(); clear_ctl();
        expect_sel("pc_inc", S_PC, 32'h0000_0006);
        expect_sel("pc_inc_zhi", S_ZH, 32'h0);
        drain();

        op = '0; op[OP_MUL] = 1;
        alu_run("mul", 32'hFFFF_FFFE, 32'h3, op);
        ref_z = alu_model(op, 32'hFFFF_FFFE, 32'h3);
`ifdef DATAPATH_MULDIV_EN
        check_eq("mul_model_hi", ref_z[63:32], 32'hFFFF_FFFF);
        check_eq("mul_model_lo", ref_z[31:0], 32'hFFFF_FFFA);
`else
        check_eq("mul_model_off", ref_z[31:0] | ref_z[63:32], 32'h0);
`endif
        op = '0; op[OP_DIV] = 1;
        alu_run("div", 32'hFFFF_FFF9, 32'h2, op);
        alu_run("div0", 32'hFFFF_FFF9, 32'h0, op);
`ifdef DATAPATH_MULDIV_EN
        ref_z = alu_model(op, 32'hFFFF_FFF9, 32'h2);
        check_eq("div_model_lo", ref_z[31:0], 32'hFFFF_FFFD);
        check_eq("div_model_hi", ref_z[63:32], 32'hFFFF_FFFF);
`endif

        op = '0; op[OP_SHRA] = 1; alu_run("shra", 32'h8000_0000, 32'h4, op);
        op = '0; op[OP_SHR] = 1;  alu_run("shr", 32'h8000_0000, 32'h4, op);
        op = '0; op[OP_ROL] = 1;  alu_run("rol", 32'h8000_0000, 32'h4, op);
        op = '0; op[OP_SHRA] = 1;
        check_eq("shra_model", alu_model(op, 32'h8000_0000, 32'h4) >> 0 == 64'hF800_0000 ? 32'h1 : 32'h0, 32'h1);

        op = '0; op[OP_ADD] = 1; op[OP_SUB] = 1; op[OP_NOT] = 1;
        alu_run("prio_add", 32'h0000_0010, 32'h0000_0003, op);
        op = '0; op[OP_SUB] = 1; op[OP_NOT] = 1;
        alu_run("prio_sub", 32'h0000_0010, 32'h0000_0003, op);

        for (int i = 0; i < 12; i++) begin
            pick = $urandom_range(0, 11);
            op = '0;
            case (pick)
                0: op[OP_ADD] = 1;  1: op[OP_SUB] = 1;  2: op[OP_SHR] = 1;
                3: op[OP_SHRA] = 1; 4: op[OP_SHL] = 1;  5: op[OP_ROR] = 1;
                6: op[OP_ROL] = 1;  7: op[OP_AND] = 1;  8: op[OP_OR] = 1;
                9: op[OP_NEG] = 1;  10: op[OP_NOT] = 1; default: op = '0;
            endcase
            alu_run($sformatf("rnd%0d_op%0d", i, pick), $urandom, $urandom, op);
        end

        // Bus priority between simultaneous out-selects
        reg_load(0, 32'h0000_00AA);
        reg_load(S_HI, 32'h0000_00BB);
        mdr_load(32'h0000_00CC);
        expect_sel("bus_r0_over_hi", S_R0_HI, 32'h0000_00AA);
        expect_sel("bus_hi_over_mdr", S_HI_MDR, 32'h0000_00BB);
        drain();

        // Z reads its own pre-edge value: Z = Y + Zlow
        alu_run("z_seed", 32'h0, 32'h40, '0);
        reg_load(99, 32'h1);
        Zlowout = 1; Zin = 1; ops[OP_ADD] = 1; tick(); clear_ctl();
        expect_sel("z_rbw", S_ZL, 32'h0000_0042);
        drain();

        // Clear overrides load enables
        reg_load(5, 32'h0000_0055);
        mdr_load(32'h0000_1234);
        Clear = 1; rin[5] = 1; MDRout = 1; tick(); clear_ctl();
        expect_sel("clr_r5", 5, 32'h0);
        expect_sel("clr_mdr", S_MDR, 32'h0);
        expect_sel("clr_zlo", S_ZL, 32'h0);
        expect_sel("clr_hi", S_HI, 32'h0);
        expect_sel("clr_bus_none", S_NONE, 32'h0);
        drain();

        mdr_load(32'h24C6_0000);
        MDRout = 1; IRin = 1; tick(); clear_ctl();
        expect_sel("ir_src_mdr", S_MDR, 32'h24C6_0000);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_path.md
DATA_PATH -- requirements
Module: DataPath

Interface
REQ-001 Port order SHALL be: Clock, Clear, HIin, HIout, LOin, LOout, PCin, PCout, IRin, Zin, Zhighout, Zlowout, Yin, MARin, MDRin, MDRout, Read, Mdatain, R0out..R15out, R0in..R15in, ADD, SUB, SHR, SHRA, SHL, ROR, ROL, AND, OR, MUL, DIV, NEG, NOT, BusMuxOut.
REQ-002 Clock  in  1  single clock; all state updates on the rising edge.
REQ-003 Clear  in  1  reset; synchronous, active-high.
REQ-004 R0out..R15out, HIout, LOout, PCout, MDRout, Zhighout, Zlowout  in  1 each  bus-drive selects.
REQ-005 R0in..R15in, HIin, LOin, PCin, IRin, Yin, Zin, MARin, MDRin  in  1 each  register load enables.
REQ-006 Read  in  1  MDR input select: 1 = Mdatain, 0 = bus.
REQ-007 Mdatain  in  32  memory read data.
REQ-008 ADD, SUB, SHR, SHRA, SHL, ROR, ROL, AND, OR, MUL, DIV, NEG, NOT  in  1 each  ALU operation selects.
REQ-009 BusMuxOut  out  32  current internal bus value (observation port).

Function
REQ-010 Storage SHALL be 32-bit R0-R15 (R0 is an ordinary register), HI, LO, PC, IR, Y, MAR, MDR, plus 64-bit Z (Zhigh = Z[63:32], Zlow = Z[31:0]).
REQ-011 Bus SHALL be combinational: value of the single asserted out-select; if several are asserted, priority is R0..R15, HI, LO, Zhigh, Zlow, PC, MDR (first wins); if none, bus = 0.
REQ-012 Each register with its in-enable high SHALL load the bus on the next rising edge; MDR loads Mdatain when Read=1, else the bus.
REQ-013 ALU SHALL be combinational with A = Y and B = bus; Z loads the 64-bit ALU result on the edge where Zin=1.
REQ-014 Operations (Z[63:32]=0 unless stated): ADD A+B; SUB A-B; AND; OR; NOT ~B; NEG 0-B; SHR A>>B[4:0] logical; SHRA arithmetic; SHL A<<B[4:0]; ROR/ROL rotate A by B[4:0].
REQ-015 MUL SHALL give the 64-bit signed product A*B; DIV SHALL give signed quotient A/B in Zlow and remainder in Zhigh (remainder takes sign of A).
REQ-016 DIV by zero SHALL give Zlow = 0xFFFFFFFF, Zhigh = A.
REQ-017 With no operation select asserted, the ALU SHALL output B+1 (PC increment: PCout+Zin gives Z = PC+1).
REQ-018 Multiple operation selects SHALL resolve by priority in REQ-001 order (ADD highest, NOT lowest).
REQ-019 Arithmetic wraps modulo 2^32 in Zlow; no flags or overflow outputs.
REQ-020 Simultaneous in-enable and out-select on one register SHALL load the pre-edge bus value (read-before-write).
REQ-021 Latency: any register transfer or ALU operation completes in one clock edge.

Reset
REQ-022 Clear=1 at a rising edge SHALL zero all registers including Z; this overrides every simultaneous load enable.
REQ-023 Clear mid-sequence SHALL discard in-flight operations; registers restart from 0.
REQ-024 After reset with no out-select asserted, BusMuxOut SHALL be 0.

Configuration
REQ-025 Macro DATAPATH_MULDIV_EN: when defined, MUL and DIV behave per REQ-015/016; when undefined, no multiplier or divider is built and MUL/DIV give Z = 0 (they keep their priority slot).

Verification
REQ-026 Load R2=0x80000012 and R3=0x4 via Mdatain/MDR; Y<-R2; R3out+ROR+Zin; Zlowout+R1in -> R1 = 0x28000001.
REQ-027 PC=0x00000005; PCout+MARin+Zin with no op; Zlowout+PCin -> MAR = 5, PC = 6.
REQ-028 Y=0xFFFFFFFE (-2), bus=3, MUL -> Zhigh = 0xFFFFFFFF, Zlow = 0xFFFFFFFA; with macro undefined -> Z = 0.
REQ-029 Y=-7, bus=2, DIV -> Zlow = 0xFFFFFFFD, Zhigh = 0xFFFFFFFF; bus=0 -> Zlow = 0xFFFFFFFF, Zhigh = 0xFFFFFFF9.
REQ-030 Y=0x80000000, bus=4, SHRA -> Zlow = 0xF8000000; SHR -> 0x08000000; ROL -> 0x00000008.
REQ-031 Assert Clear with R5in=1 and MDRout=1 -> all registers 0 after the edge; Read=1+MDRin=1 with Mdatain=0x24C60000, then MDRout+IRin -> IR = 0x24C60000.
